// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing a single uart_tx among NUM_REQ requesters, one byte per grant.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the uart_tx done handshake (TIMEOUT_CLKS >= 2).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 1248
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic [NUM_REQ-1:0]   o_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_found;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               done_fire;
    logic               timeout_fire;
    logic [7:0]         req_bytes [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
        assign req_bytes[k] = i_Req_Byte[8*k +: 8];
    end

    // Search starts just past the last winner, so a continuously held request
    // cannot win again until every other active requester has been served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!sel_found && i_Req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign grant_onehot = NUM_REQ'(1) << grant_idx;
    assign done_fire    = (state == WAIT_DONE) && i_Tx_Done;
    assign o_Busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        o_Tx_DV    = 1'b0;
        o_Ack      = '0;
        case (state)
            IDLE: begin
                if (sel_found && !i_Tx_Active) state_next = LOAD;
            end
            LOAD: begin
                o_Tx_DV    = 1'b1;
                o_Ack      = grant_onehot;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Tx_Done || timeout_fire) state_next = GAP;
            end
            GAP: begin
                if (!i_Tx_Active) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // uart_tx has no reset, so after our reset it may still be finishing a
    // frame; the i_Tx_Active check in IDLE keeps us from issuing DV over it.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
            o_Tx_Byte <= '0;
            o_Done    <= '0;
        end else begin
            state  <= state_next;
            o_Done <= done_fire ? grant_onehot : '0;
            if (state == IDLE && state_next == LOAD) begin
                grant_idx <= sel_idx;
                ptr       <= sel_idx;
                o_Tx_Byte <= req_bytes[sel_idx];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TMR_W-1:0] timer;

    // Timer is 0 in the first WAIT_DONE cycle, so the abort pulse lands exactly
    // TIMEOUT_CLKS cycles after the DV cycle.
    assign timeout_fire = (state == WAIT_DONE) && !i_Tx_Done &&
                          (timer == TMR_W'(TIMEOUT_CLKS - 2));

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            timer     <= '0;
            o_Timeout <= 1'b0;
        end else begin
            o_Timeout <= timeout_fire;
            if (state == LOAD) begin
                timer <= '0;
            end else if (state == WAIT_DONE) begin
                timer <= timer + 1'b1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign o_Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stand-in and ack/done scoreboards.
// Define UART_ARB_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int TIMEOUT_CLKS = 50;
    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME        = 10 * CLKS_PER_BIT;
    localparam int WAIT_LIMIT   = 500;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } item_t;

    logic                 clock      = 1'b0;
    logic                 i_Rst_L    = 1'b0;
    logic [NUM_REQ-1:0]   i_Req      = '0;
    logic [8*NUM_REQ-1:0] i_Req_Byte = '0;
    logic [NUM_REQ-1:0]   o_Ack;
    logic [NUM_REQ-1:0]   o_Done;
    logic                 o_Busy;
    logic                 o_Timeout;
    logic                 o_Tx_DV;
    logic [7:0]           o_Tx_Byte;

    logic       m_active      = 1'b0;
    logic       m_done        = 1'b0;
    logic       m_cleanup     = 1'b0;
    logic       suppress_done = 1'b0;
    logic [7:0] m_byte        = '0;
    int         m_cnt         = 0;

    int   total         = 0;
    int   bad           = 0;
    int   cyc           = 0;
    int   ack_count     = 0;
    int   done_count    = 0;
    int   timeout_count = 0;
    int   md_rise_cyc   = -100;
    logic md_prev       = 1'b0;
    logic dv_armed      = 1'b0;

    item_t ack_q[$];
    item_t done_q[$];

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_Clock    (clock),
        .i_Rst_L    (i_Rst_L),
        .i_Req      (i_Req),
        .i_Req_Byte (i_Req_Byte),
        .o_Ack      (o_Ack),
        .o_Done     (o_Done),
        .o_Busy     (o_Busy),
        .o_Timeout  (o_Timeout),
        .o_Tx_DV    (o_Tx_DV),
        .o_Tx_Byte  (o_Tx_Byte),
        .i_Tx_Active(m_active),
        .i_Tx_Done  (m_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for uart_tx: no reset, Active rises after DV, Done high for two
    // cycles (stop-bit end plus cleanup) with Active dropping on the first.
    always @(posedge clock) begin
        if (m_cleanup) m_cleanup <= 1'b0;
        if (m_cnt == 0) begin
            m_done <= m_cleanup && !suppress_done;
            if (o_Tx_DV && !m_cleanup) begin
                m_active <= 1'b1;
                m_byte   <= o_Tx_Byte;
                m_cnt    <= FRAME;
            end
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else begin
            m_cnt     <= 0;
            m_active  <= 1'b0;
            m_done    <= !suppress_done;
            m_cleanup <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clock) begin
        item_t e;
        if (m_done && !md_prev) md_rise_cyc = cyc;
        md_prev = m_done;
        if (o_Tx_DV || o_Ack != '0) begin
            ack_count++;
            if (ack_q.size() == 0) begin
                checkOutput("ack_unexpected", {27'd0, o_Tx_DV, o_Ack}, 32'd0);
            end else begin
                e = ack_q.pop_front();
                checkOutput("ack_onehot", {28'd0, o_Ack}, 32'd1 << e.idx);
                checkOutput("ack_dv", {31'd0, o_Tx_DV}, 32'd1);
                checkOutput("ack_byte", {24'd0, o_Tx_Byte}, {24'd0, e.data});
                checkOutput("ack_no_overlap", {31'd0, m_active | m_cleanup}, 32'd0);
                if (dv_armed) checkOutput("done_to_dv_ge3", {31'd0, (cyc - md_rise_cyc) >= 3}, 32'd1);
            end
            dv_armed = 1'b0;
        end
        if (o_Done != '0) begin
            done_count++;
            if (done_q.size() == 0) begin
                checkOutput("done_unexpected", {28'd0, o_Done}, 32'd0);
            end else begin
                e = done_q.pop_front();
                checkOutput("done_onehot", {28'd0, o_Done}, 32'd1 << e.idx);
                checkOutput("done_byte_sent", {24'd0, m_byte}, {24'd0, e.data});
                checkOutput("done_latency", cyc, md_rise_cyc + 1);
            end
            dv_armed = 1'b1;
        end
        if (o_Busy && m_active) checkOutput("tx_byte_stable", {24'd0, o_Tx_Byte}, {24'd0, m_byte});
        if (o_Timeout) timeout_count++;
`ifndef UART_ARB_TIMEOUT_EN
        checkOutput("timeout_tied_low", {31'd0, o_Timeout}, 32'd0);
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [8*NUM_REQ-1:0] bytes);
        i_Req_Byte = bytes;
        i_Req      = req;
    endtask

    task automatic expectGrant(input int idx, input bit with_done);
        item_t e;
        e.idx  = idx;
        e.data = i_Req_Byte[8*idx +: 8];
        ack_q.push_back(e);
        if (with_done) done_q.push_back(e);
    endtask

    task automatic applyReset();
        i_Rst_L  = 1'b0;
        dv_armed = 1'b0;
        step(1);
        checkOutput("rst_ack", {28'd0, o_Ack}, 32'd0);
        checkOutput("rst_done", {28'd0, o_Done}, 32'd0);
        checkOutput("rst_busy", {31'd0, o_Busy}, 32'd0);
        checkOutput("rst_dv", {31'd0, o_Tx_DV}, 32'd0);
        checkOutput("rst_timeout", {31'd0, o_Timeout}, 32'd0);
        checkOutput("rst_tx_byte", {24'd0, o_Tx_Byte}, 32'd0);
        step(1);
        i_Rst_L = 1'b1;
        step(1);
    endtask

    task automatic waitAcks(input int target);
        int n = 0;
        while (ack_count < target && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        checkOutput("ack_wait", {31'd0, ack_count >= target}, 32'd1);
    endtask

    task automatic waitDones(input int target);
        int n = 0;
        while (done_count < target && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        checkOutput("done_wait", {31'd0, done_count >= target}, 32'd1);
    endtask

    task automatic waitTimeouts(input int target);
        int n = 0;
        while (timeout_count < target && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        checkOutput("timeout_wait", {31'd0, timeout_count >= target}, 32'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((o_Busy || m_active || m_cleanup) && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        checkOutput("idle_wait", {31'd0, o_Busy}, 32'd0);
    endtask

    initial begin
        int base;
        int dbase;
        int dv_cyc;

        // Single request from requester 2: Ack exactly one cycle after sampling.
        applyReset();
        checkOutput("idle_busy_after_reset", {31'd0, o_Busy}, 32'd0);
        applyStimulus(4'b0000, {8'h00, 8'h41, 8'h00, 8'h00});
        expectGrant(2, 1'b1);
        dbase = done_count;
        applyStimulus(4'b0100, i_Req_Byte);
        step(1);
        checkOutput("single_ack_latency", {28'd0, o_Ack}, 32'h4);
        checkOutput("single_busy", {31'd0, o_Busy}, 32'd1);
        i_Req = '0;
        step(1);
        checkOutput("single_dv_one_cycle", {31'd0, o_Tx_DV}, 32'd0);
        waitDones(dbase + 1);
        waitIdle();

        // All four held: rotation 0,1,2,3,0.
        applyReset();
        applyStimulus(4'b0000, {8'h44, 8'h43, 8'h42, 8'h41});
        expectGrant(0, 1'b1);
        expectGrant(1, 1'b1);
        expectGrant(2, 1'b1);
        expectGrant(3, 1'b1);
        expectGrant(0, 1'b1);
        base  = ack_count;
        dbase = done_count;
        applyStimulus(4'b1111, i_Req_Byte);
        waitAcks(base + 5);
        i_Req = '0;
        waitDones(dbase + 5);
        waitIdle();

        // Requesters 0 and 1, with 0 re-raised after each Ack: 0,1,0,1.
        applyReset();
        applyStimulus(4'b0000, {8'h00, 8'h00, 8'h31, 8'h30});
        for (int k = 0; k < 4; k++) expectGrant(k % 2, 1'b1);
        base  = ack_count;
        dbase = done_count;
        applyStimulus(4'b0011, i_Req_Byte);
        for (int k = 1; k <= 4; k++) begin
            waitAcks(base + k);
            if (o_Ack[0] && k < 4) begin
                i_Req[0] = 1'b0;
                step(1);
                i_Req[0] = 1'b1;
            end
        end
        i_Req = '0;
        waitDones(dbase + 4);
        waitIdle();

        // Reset mid-frame of requester 1: its Done is lost, next DV waits for Active to fall.
        applyReset();
        applyStimulus(4'b0000, {8'h00, 8'h00, 8'h55, 8'h5A});
        expectGrant(1, 1'b0);
        base  = ack_count;
        dbase = done_count;
        applyStimulus(4'b0010, i_Req_Byte);
        waitAcks(base + 1);
        dv_cyc = cyc;
        i_Req  = '0;
        step(15);
        applyReset();
        expectGrant(0, 1'b1);
        applyStimulus(4'b0011, i_Req_Byte);
        waitAcks(base + 2);
        i_Req = '0;
        checkOutput("post_reset_dv_after_frame", {31'd0, cyc >= dv_cyc + FRAME + 2}, 32'd1);
        waitDones(dbase + 1);
        waitIdle();
        step(5);
        checkOutput("post_reset_done_count", done_count, dbase + 1);

        // Requester 3 withdraws before being served while 2 is on the line.
        applyReset();
        applyStimulus(4'b0000, {8'h33, 8'h32, 8'h00, 8'h00});
        expectGrant(2, 1'b1);
        base  = ack_count;
        dbase = done_count;
        applyStimulus(4'b0100, i_Req_Byte);
        waitAcks(base + 1);
        i_Req = '0;
        step(10);
        i_Req = 4'b1000;
        step(10);
        i_Req = '0;
        waitDones(dbase + 1);
        waitIdle();
        step(5);
        checkOutput("withdrawn_no_ack", ack_count, base + 1);
        checkOutput("withdrawn_no_done", done_count, dbase + 1);

`ifdef UART_ARB_TIMEOUT_EN
        // Done suppressed: each grant aborts at DV+TIMEOUT_CLKS and the next requester is served.
        suppress_done = 1'b1;
        applyReset();
        applyStimulus(4'b0000, {8'h00, 8'h00, 8'h71, 8'h70});
        expectGrant(0, 1'b0);
        expectGrant(1, 1'b0);
        base  = ack_count;
        dbase = done_count;
        applyStimulus(4'b0011, i_Req_Byte);
        waitAcks(base + 1);
        i_Req  = 4'b0010;
        dv_cyc = cyc;
        waitTimeouts(1);
        checkOutput("timeout_at_dv_plus", cyc, dv_cyc + TIMEOUT_CLKS);
        step(1);
        checkOutput("timeout_one_cycle", {31'd0, o_Timeout}, 32'd0);
        waitAcks(base + 2);
        i_Req = '0;
        waitTimeouts(2);
        waitIdle();
        checkOutput("timeout_no_done", done_count, dbase);
        suppress_done = 1'b0;
`endif

        checkOutput("queues_drained", ack_q.size() + done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
